// File: rtl/modinv_fermat_2203.sv
// modinv_fermat_2203: GF(2203) inverse via Fermat square-and-multiply over a Barrett reducer
module modinv_fermat_2203 #(
    parameter int Q   = 2203,
    parameter int W   = 12,
    parameter int MU  = 7615,
    parameter int K   = 12,
    parameter int EXP = 2201
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din_a,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [W-1:0] dout_r,
    output logic         dout_err,
    output logic         dout_valid,
    input  logic         dout_ready
);
    localparam int W2 = 2 * W;
    localparam logic [W2-1:0] Q2 = W2'(Q);
    localparam logic [W2-1:0] MU2 = W2'(MU);
    localparam logic [W-1:0] QW = W'(Q);
    localparam logic [W-1:0] EXP_V = W'(EXP);
    localparam logic [3:0] IDX_TOP = 4'(W - 1);
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] acc, acc_nx, base, base_nx, din_red, red;
    logic [3:0] idx, idx_nx;
    logic err_q, err_nx;
    logic [W2-1:0] prod;
    // Quotient estimate undershoots by at most 2, so two trailing subtractions make it exact
    function automatic logic [W-1:0] redc(input logic [W2-1:0] x);
        logic [W2-1:0] t, r;
        t = ((x >> K) * MU2) >> K;
        r = x - t * Q2;
        if (r >= Q2) r = r - Q2;
        if (r >= Q2) r = r - Q2;
        return r[W-1:0];
    endfunction
    assign din_red = din_a >= QW ? din_a - QW : din_a;
    assign prod = W2'(acc) * W2'(state == MUL ? base : acc);
    assign red = redc(prod);
    assign din_ready = state == IDLE;
    assign dout_valid = state == DONE;
    assign dout_r = dout_valid ? acc : '0;
    assign dout_err = dout_valid & err_q;
    always_comb begin
        state_nx = state;
        acc_nx = acc;
        base_nx = base;
        idx_nx = idx;
        err_nx = err_q;
        case (state)
            IDLE: if (din_valid) begin
                base_nx = din_red;
                err_nx = din_red == '0;
                acc_nx = W'(1);
                idx_nx = IDX_TOP;
                state_nx = SQR;
            end
            SQR: begin
                acc_nx = red;
                if (EXP_V[idx]) state_nx = MUL;
                else if (idx == '0) state_nx = DONE;
                else idx_nx = idx - 4'd1;
            end
            MUL: begin
                acc_nx = red;
                state_nx = idx == '0 ? DONE : SQR;
                idx_nx = idx == '0 ? idx : idx - 4'd1;
            end
            DONE: state_nx = dout_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc <= W'(1);
            base <= '0;
            idx <= IDX_TOP;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            acc <= acc_nx;
            base <= base_nx;
            idx <= idx_nx;
            err_q <= err_nx;
        end
    end
endmodule

// File: tb/tb_modinv_fermat_2203.sv
// tb_modinv_fermat_2203: scoreboard bench for the GF(2203) Fermat inverter
module tb_modinv_fermat_2203;
    logic clk = 0, rst_n = 0, din_valid = 0, dout_ready = 1;
    logic [11:0] din_a = 0, dout_r;
    logic din_ready, dout_err, dout_valid;
    int n_chk = 0, n_fail = 0;
    typedef struct {int a; logic [11:0] r; logic e;} exp_t;
    exp_t sb[$];

    modinv_fermat_2203 dut (.clk(clk), .rst_n(rst_n), .din_a(din_a), .din_valid(din_valid),
        .din_ready(din_ready), .dout_r(dout_r), .dout_err(dout_err), .dout_valid(dout_valid),
        .dout_ready(dout_ready));

    always #5 clk = ~clk;

    function automatic logic [11:0] model_inv(int a);
        longint b = a % 2203, res = 1;
        int e = 2201;
        while (e > 0) begin
            if (e[0]) res = (res * b) % 2203;
            b = (b * b) % 2203;
            e = e >> 1;
        end
        return 12'(res);
    endfunction

    task automatic send(int a);
        int n = 0;
        exp_t x;
        din_a = 12'(a);
        din_valid = 1;
        while (!din_ready && n < 50) begin @(posedge clk); #1; n++; end
        n_chk++;
        if (!din_ready) begin n_fail++; $display("FAIL send_timeout a=%0d din_ready=%b required 1", a, din_ready); end
        @(posedge clk); #1;
        din_valid = 0;
        x.a = a; x.r = model_inv(a); x.e = (a % 2203) == 0;
        sb.push_back(x);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!dout_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        n_chk++;
        if (!dout_valid) begin n_fail++; $display("FAIL out_timeout dout_valid=%b after %0d cycles required 1", dout_valid, cyc); end
    endtask

    task automatic test_reset;
        n_chk++;
        if ({din_ready, dout_valid, dout_r, dout_err} !== {1'b1, 1'b0, 12'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset rdy=%b vld=%b r=%0d err=%b required 1 0 0 0", din_ready, dout_valid, dout_r, dout_err);
        end
    endtask

    task automatic test_ops;
        int ops[7] = '{2, 1, 3, 2202, 2205, 0, 2203};
        int cyc;
        exp_t x;
        foreach (ops[i]) begin
            send(ops[i]);
            wait_out(cyc);
            x = sb.pop_front();
            n_chk++;
            if (cyc != 17) begin n_fail++; $display("FAIL latency a=%0d got %0d required 17", x.a, cyc); end
            n_chk++;
            if (dout_r !== x.r || dout_err !== x.e) begin
                n_fail++;
                $display("FAIL result a=%0d r=%0d err=%b required r=%0d err=%b", x.a, dout_r, dout_err, x.r, x.e);
            end
            if (!x.e) begin
                n_chk++;
                if ((x.a * int'(dout_r)) % 2203 != 1) begin n_fail++; $display("FAIL inverse a=%0d r=%0d product not 1", x.a, dout_r); end
            end
            @(posedge clk); #1;
            n_chk++;
            if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL turnaround a=%0d vld=%b rdy=%b required 0 1", x.a, dout_valid, din_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        exp_t x;
        dout_ready = 0;
        send(5);
        wait_out(cyc);
        x = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            din_a = 12'd7;
            din_valid = (i == 2);
            @(posedge clk); #1;
            n_chk++;
            if (dout_valid !== 1'b1 || dout_r !== x.r || dout_err !== 1'b0 || din_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure cyc=%0d vld=%b r=%0d err=%b rdy=%b required 1 %0d 0 0", i, dout_valid, dout_r, dout_err, din_ready, x.r);
            end
        end
        din_valid = 0;
        dout_ready = 1;
        @(posedge clk); #1;
        n_chk++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release vld=%b rdy=%b required 0 1", dout_valid, din_ready);
        end
        repeat (20) @(posedge clk);
        #1;
        n_chk++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ghost vld=%b required 0", dout_valid); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        exp_t x;
        send(10);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        n_chk++;
        if ({din_ready, dout_valid, dout_r, dout_err} !== {1'b1, 1'b0, 12'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset rdy=%b vld=%b r=%0d err=%b required 1 0 0 0", din_ready, dout_valid, dout_r, dout_err);
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1;
        send(3);
        wait_out(cyc);
        x = sb.pop_front();
        n_chk++;
        if (cyc != 17 || dout_r !== 12'd1469 || x.r !== 12'd1469) begin
            n_fail++;
            $display("FAIL after_reset lat=%0d r=%0d required 17 1469", cyc, dout_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep;
        int cyc;
        exp_t x;
        for (int a = 1; a < 2203; a++) begin
            send(a);
            wait_out(cyc);
            x = sb.pop_front();
            n_chk++;
            if (cyc != 17 || dout_r !== x.r || dout_err !== 1'b0 || (a * int'(dout_r)) % 2203 != 1) begin
                n_fail++;
                $display("FAIL sweep a=%0d lat=%0d r=%0d err=%b required 17 %0d 0", a, cyc, dout_r, dout_err, x.r);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2;
        test_reset;
        @(posedge clk); #1;
        rst_n = 1;
        test_reset;
        test_ops;
        test_backpressure;
        test_reset_mid;
        test_sweep;
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left %0d required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
